// File: rtl/isqrt_pkg.sv
// Shared types and constants for the sequential integer square root unit.
package isqrt_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root width and iteration count for a given radicand width.
  function automatic int unsigned iter_of(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/isqrt_if.sv
// Request/result bundle between a radicand source and the square root unit.
interface isqrt_if
  import isqrt_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  localparam int unsigned ITER = iter_of(WIDTH);

  logic              start;
  logic [WIDTH-1:0]  radicand;
  logic              busy;
  logic              done;
  logic [ITER-1:0]   root;
  logic [ITER:0]     remainder;

  modport master (
    output start, radicand,
    input  busy, done, root, remainder
  );

  modport slave (
    input  start, radicand,
    output busy, done, root, remainder
  );

endinterface

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: consume two radicand bits, emit one root bit.
module isqrt_step #(
  parameter int unsigned ITER = 4
) (
  input  logic [ITER+1:0] rem,
  input  logic [ITER-1:0] proot,
  input  logic [1:0]      bits,
  output logic [ITER+1:0] rem_next,
  output logic [ITER-1:0] proot_next
);

  localparam int unsigned EXT_W = ITER + 4;

  logic [EXT_W-1:0] r_ext;
  logic [EXT_W-1:0] t_ext;
  logic             ge;

  // Extended width keeps the trial comparison free of wraparound.
  always_comb begin
    r_ext      = {rem, bits};
    t_ext      = EXT_W'({proot, 2'b01});
    ge         = (r_ext >= t_ext);
    rem_next   = ge ? (ITER+2)'(r_ext - t_ext) : (ITER+2)'(r_ext);
    proot_next = ITER'({proot, ge});
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per clock.
// Optional rounding of the root output is enabled with `define ISQRT_ROUND_EN.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  isqrt_if.slave bus
);

  localparam int unsigned ITER  = iter_of(WIDTH);
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] shreg;
  logic [ITER-1:0]  proot;
  logic [ITER+1:0]  prem;
  logic [CNT_W-1:0] cnt;
  logic [ITER-1:0]  root_q;
  logic [ITER:0]    rem_q;
  logic             busy_q;
  logic             done_q;

  logic             last;
  logic             load;
  logic             step;
  logic             busy_nxt;
  logic             done_nxt;

  logic [ITER+1:0]  rem_next;
  logic [ITER-1:0]  proot_next;
  logic [ITER-1:0]  root_final;

  assign last = (cnt == '0);

  isqrt_step #(.ITER(ITER)) u_step (
    .rem        (prem),
    .proot      (proot),
    .bits       (shreg[WIDTH-1 -: 2]),
    .rem_next   (rem_next),
    .proot_next (proot_next)
  );

`ifdef ISQRT_ROUND_EN
  logic [ITER:0] root_inc;
  assign root_inc = {1'b0, proot_next} + (ITER+1)'(1);

  // Round up when the remainder passes the midpoint, saturating at all-ones.
  always_comb begin
    root_final = proot_next;
    if (rem_next[ITER:0] > {1'b0, proot_next}) begin
      root_final = root_inc[ITER] ? '1 : root_inc[ITER-1:0];
    end
  end
`else
  assign root_final = proot_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    busy_nxt = (state_next != IDLE);
    done_nxt = (state_next == DONE);
    if (state == IDLE && bus.start) load = 1'b1;
    if (state == CALC)              step = 1'b1;
  end

  // Datapath and registered outputs; the result registers only move on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      proot  <= '0;
      prem   <= '0;
      cnt    <= '0;
      root_q <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (load) begin
        shreg <= bus.radicand;
        proot <= '0;
        prem  <= '0;
        cnt   <= CNT_W'(ITER - 1);
      end else if (step) begin
        shreg <= shreg << 2;
        proot <= proot_next;
        prem  <= rem_next;
        cnt   <= cnt - CNT_W'(1);
        if (last) begin
          root_q <= root_final;
          rem_q  <= rem_next[ITER:0];
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.root      = root_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed self-checking bench for isqrt_seq (WIDTH=8); honours ISQRT_ROUND_EN.
module tb_isqrt_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ITER  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  isqrt_if #(.WIDTH(WIDTH)) bus ();

  isqrt_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected root for a floor root / remainder pair, including optional rounding.
  function automatic int exp_root(input int fr, input int frem);
`ifdef ISQRT_ROUND_EN
    if (frem > fr) return (fr + 1 > 15) ? 15 : fr + 1;
    return fr;
`else
    if (frem < 0) return -1;
    return fr;
`endif
  endfunction

  // Accept one radicand and wait (bounded) for done; returns result and latency.
  task automatic run_op(input int rad, output int r, output int rm, output int lat);
    bus.radicand = WIDTH'(rad);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    r   = -1;
    rm  = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        r   = int'(bus.root);
        rm  = int'(bus.remainder);
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  int r, rm, lat, bc, dcnt, dcyc, droot, drem, fr, frem;

  initial begin
    bus.start    = 1'b0;
    bus.radicand = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_root", int'(bus.root), 0);
    check("rst_rem",  int'(bus.remainder), 0);

    // radicand 0: latency and busy window
    bus.radicand = 8'd0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    bc = 0; dcnt = 0; dcyc = -1; droot = -1; drem = -1;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) begin
        dcnt++;
        dcyc  = i;
        droot = int'(bus.root);
        drem  = int'(bus.remainder);
      end
      tick();
    end
    check("zero_busy_cycles", bc, 5);
    check("zero_done_pulses", dcnt, 1);
    check("zero_done_cycle", dcyc, ITER);
    check("zero_root", droot, 0);
    check("zero_rem", drem, 0);

    run_op(16, r, rm, lat);
    check("r16_lat", lat, ITER);
    check("r16_root", r, 4);
    check("r16_rem", rm, 0);
    tick();
    check("r16_done_drop", int'(bus.done), 0);
    check("r16_busy_drop", int'(bus.busy), 0);
    check("r16_hold_root", int'(bus.root), 4);

    // root output must hold old value while the next computation runs
    bus.radicand = 8'd48;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("r48_mid_hold_root", int'(bus.root), 4);
    check("r48_mid_busy", int'(bus.busy), 1);
    for (int i = 0; i < 10 && bus.done !== 1'b1; i++) tick();
    check("r48_root", int'(bus.root), exp_root(6, 12));
    check("r48_rem", int'(bus.remainder), 12);
    tick();

    run_op(255, r, rm, lat);
    check("r255_root", r, 15);
    check("r255_rem", rm, 30);
    tick();

    // start held high with another radicand during CALC/DONE is ignored
    bus.radicand = 8'd81;
    bus.start    = 1'b1;
    tick();
    bus.radicand = 8'd4;
    dcnt = 0; droot = -1; drem = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        dcnt++;
        droot = int'(bus.root);
        drem  = int'(bus.remainder);
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("r81_done_pulses", dcnt, 1);
    check("r81_root", droot, 9);
    check("r81_rem", drem, 0);
    check("r81_final_root", int'(bus.root), 9);
    check("r81_idle_busy", int'(bus.busy), 0);

    // reset on the second CALC edge aborts the computation
    bus.radicand = 8'd200;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_root", int'(bus.root), 0);
    check("abort_rem", int'(bus.remainder), 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    check("abort_no_done", dcnt, 0);
    check("abort_stays_idle", int'(bus.busy), 0);

    run_op(200, r, rm, lat);
    check("r200_root", r, exp_root(14, 4));
    check("r200_rem", rm, 4);
    tick();

    // full sweep against a floor-sqrt reference
    for (int v = 0; v < 256; v++) begin
      fr = 0;
      while ((fr + 1) * (fr + 1) <= v) fr++;
      frem = v - fr * fr;
      run_op(v, r, rm, lat);
      check($sformatf("sweep_root_%0d", v), r, exp_root(fr, frem));
      check($sformatf("sweep_rem_%0d", v), rm, frem);
      check($sformatf("sweep_lat_%0d", v), lat, ITER);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
Sequential digit-by-digit (restoring) integer square root unit that sits directly downstream of the 4-bit CLA adder.
- Consumes the zero-extended adder sum as its radicand.
- Produces floor(sqrt), plus remainder, for the seven-segment drivers.
- Produces one root bit per clock; the result is held stable for display until the next start.

Parameters:
- WIDTH, 8, radicand width in bits; must be even and >= 2.
- ITER, WIDTH/2, iteration count and root width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- radicand  input  WIDTH  value to root; sampled on the accepting edge only.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; result valid.
- root  output  ITER  floor(sqrt(radicand)); optionally rounded (see Optional Feature).
- remainder  output  ITER+1  radicand - floor_root^2; always the truncated remainder.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, root=0, remainder=0; internal shift, partial-remainder and iteration-counter registers = 0.
- Reset has priority over everything, including mid-CALC; the partial result is discarded and done is not pulsed.
- IDLE -> CALC on an edge with start=1:
  - load radicand into shift register; clear partial root and partial remainder; counter=ITER-1.
  - root/remainder outputs keep their previous values until the result is written.
- CALC, each edge:
  - r' = (rem<<2) | top two radicand bits; shift radicand left by 2.
  - t = (proot<<2) | 1.
  - if r' >= t: rem=r'-t, proot=(proot<<1)|1; else rem=r', proot=proot<<1.
  - counter decrements; the edge with counter==0 performs the last iteration, writes root/remainder outputs and moves to DONE.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE.
- Latency: start sampled at edge k; done high in the cycle after edge k+ITER (ITER+1 edges after acceptance). Throughput: one result per ITER+2 cycles.
- start in CALC or DONE is ignored; no queuing. radicand changes after acceptance have no effect.
- Width rules:
  - partial remainder register ITER+2 bits wide, so the comparison never overflows;
  - the remainder output drops the MSB, since max remainder is 2*root <= 2^(ITER+1)-2.
- Boundaries: radicand 0 -> root 0, rem 0. radicand 2^WIDTH-1 -> root 2^ITER-1, rem 2^(ITER+1)-2.

Optional Feature:
- Macro: ISQRT_ROUND_EN.
- Defined:
  - root output = floor_root+1 when truncated remainder > floor_root, else floor_root;
  - saturate at 2^ITER-1;
  - applied on the final CALC edge, so latency is unchanged; remainder output still truncated.
- Undefined: root = floor_root; no rounding logic synthesised.

Decomposition:
- Shared package isqrt_pkg:
  - state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - ITER derivation helper;
  - default WIDTH constant 8.
- One natural sub-module, isqrt_step: purely combinational single iteration.
  - Inputs: rem, proot, two radicand bits.
  - Outputs: next rem, next proot.
  - Parameterised by ITER; instantiated once in the sequential shell.

Test Plan:
- radicand=0, start pulse -> done at edge k+ITER+1; root=0, remainder=0; busy high for exactly 5 cycles (WIDTH=8).
- radicand=16 -> root=4, remainder=0. radicand=48 -> root=6, remainder=12 (ISQRT_ROUND_EN: root=7, remainder=12).
- radicand=255 -> root=15, remainder=30 (ISQRT_ROUND_EN: root saturates at 15).
- Accept radicand=81, raise start=1 with radicand=4 during CALC and DONE -> single done pulse; root=9, remainder=0; no second computation.
- Accept radicand=200, assert rst on the 2nd CALC edge -> next cycle state=IDLE, busy=0, root=0, remainder=0, done never pulsed; then radicand=200 -> root=14, remainder=4.
- Exhaustive sweep 0..255 back-to-back against a reference model -> root^2 + remainder == radicand and remainder <= 2*root for every value.
